// File: rtl/estu_mmu_pkg.sv
// Shared definitions for the MMU address-event stack: FSM encoding, sizing
// defaults and the address-width helper used by push and pop stages.
package estu_mmu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } stack_state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 256;

  // Ceiling log2; DEPTH is a power of two so this is the exact pointer width.
  function automatic int clogb2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ae_stack_ram.sv
// Simple dual-port stack storage: one write port and one synchronous read
// port with a registered, resettable output. Written to infer block RAM.
module ae_stack_ram
  import estu_mmu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = clogb2(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register holds its value whenever no read is requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ae_stack_push.sv
// Push-side AE stack: fills a LIFO from the event source, kicks the pop
// controller with stream_out, serves its reads/pops and flags the drain.
module ae_stack_push
  import estu_mmu_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = clogb2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic              fill_end,
  output logic              stream_out,
  input  logic              rd_en,
  input  logic              pop_en,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_done,
  output logic              last_op,
  output logic [ADDR_W:0]   level,
  output logic              underflow
);

  localparam logic [ADDR_W:0] SP_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] SP_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] SP_FULL = (ADDR_W + 1)'(DEPTH);

  stack_state_t      state;
  stack_state_t      next_state;
  logic [ADDR_W:0]   sp;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              push_ok;
  logic              pop_ok;
  logic              rd_ok;
  logic              stream_next;
  logic              last_next;

  assign push_ok = push_ready && push_valid;
  assign pop_ok  = (state == ST_DRAIN) && pop_en && (sp != '0);
  assign rd_ok   = (state == ST_DRAIN) && rd_en && (sp != '0);
  assign wr_addr = ADDR_W'(sp);
  assign rd_addr = ADDR_W'(sp - SP_ONE);
  assign level   = sp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A push coinciding with fill_end is still stored; only the state moves on.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (fill_end) begin
          next_state = ST_DRAIN;
        end else if (push_ok) begin
          next_state = ST_FILL;
        end
      end
      ST_FILL: begin
        if (fill_end || (push_ok && (sp == SP_LAST))) begin
          next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((sp == '0) && !pop_en) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // push_ready is held low while reset is asserted so nothing lands mid-reset.
  always_comb begin
    push_ready  = 1'b0;
    stream_next = 1'b0;
    last_next   = 1'b0;
    case (state)
      ST_IDLE: push_ready = !rst;
      ST_FILL: push_ready = !rst && (sp != SP_FULL);
      ST_DONE: last_next  = 1'b1;
      default: push_ready = 1'b0;
    endcase
    if (((state == ST_IDLE) || (state == ST_FILL)) && (next_state == ST_DRAIN)) begin
      stream_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp         <= '0;
      stream_out <= 1'b0;
      pop_done   <= 1'b0;
      last_op    <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (push_ok) begin
        sp <= sp + SP_ONE;
      end else if (pop_ok) begin
        sp <= sp - SP_ONE;
      end
      stream_out <= stream_next;
      pop_done   <= pop_ok;
      last_op    <= last_next;
      if (pop_en && (sp == '0)) begin
        underflow <= 1'b1;
      end
    end
  end

  ae_stack_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (push_ok),
    .wr_addr(wr_addr),
    .wr_data(push_data),
    .rd_en  (rd_ok),
    .rd_addr(rd_addr),
    .rd_data(pop_data)
  );

endmodule

// File: tb/tb_ae_stack_push.sv
// Self-checking bench for ae_stack_push: directed scenarios plus randomized
// fill/drain traffic checked against a queue-based LIFO model.
module tb_ae_stack_push;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int LW     = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] push_data;
  logic              push_valid;
  logic              push_ready;
  logic              fill_end;
  logic              stream_out;
  logic              rd_en;
  logic              pop_en;
  logic [DATA_W-1:0] pop_data;
  logic              pop_done;
  logic              last_op;
  logic [LW-1:0]     level;
  logic              underflow;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] stk[$];
  logic [DATA_W-1:0] exp_data;

  ae_stack_push #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .push_data (push_data),
    .push_valid(push_valid),
    .push_ready(push_ready),
    .fill_end  (fill_end),
    .stream_out(stream_out),
    .rd_en     (rd_en),
    .pop_en    (pop_en),
    .pop_data  (pop_data),
    .pop_done  (pop_done),
    .last_op   (last_op),
    .level     (level),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    push_valid = 1'b0;
    fill_end   = 1'b0;
    rd_en      = 1'b0;
    pop_en     = 1'b0;
  endtask

  task automatic wait_last_op(input string tag);
    bit seen;
    seen = 1'b0;
    idle_inputs();
    for (int k = 0; k < 8 && !seen; k++) begin
      step();
      if (last_op === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s_last_op: got=none exp=pulse within 8 cycles", tag);
    end
    stk.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    push_data = '0;
    rst = 1'b1;
    step();
    step();
    checks++; if (push_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_push_ready: got=%0b exp=0", push_ready); end
    checks++; if (level !== '0) begin errors++; $display("[TB] FAIL reset_level: got=%0d exp=0", level); end
    checks++; if (pop_data !== '0) begin errors++; $display("[TB] FAIL reset_pop_data: got=%h exp=0", pop_data); end
    checks++; if ({stream_out, pop_done, last_op, underflow} !== 4'b0) begin errors++; $display("[TB] FAIL reset_flags: got=%b exp=0000", {stream_out, pop_done, last_op, underflow}); end
    rst = 1'b0;
    #1;
    checks++; if (push_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready: got=%0b exp=1", push_ready); end
    stk.delete();
    exp_data = '0;
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] words [3];
    logic [DATA_W-1:0] expv [3];
    words = '{16'h0011, 16'h0022, 16'h0033};
    expv  = '{16'h0033, 16'h0022, 16'h0011};
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1;
      push_data  = words[i];
      step();
      checks++; if (level !== LW'(i + 1)) begin errors++; $display("[TB] FAIL basic_push_level: got=%0d exp=%0d", level, i + 1); end
    end
    idle_inputs();
    fill_end = 1'b1;
    step();
    fill_end = 1'b0;
    checks++; if (stream_out !== 1'b1) begin errors++; $display("[TB] FAIL basic_stream_out: got=%0b exp=1", stream_out); end
    checks++; if (level !== LW'(3)) begin errors++; $display("[TB] FAIL basic_level: got=%0d exp=3", level); end
    checks++; if (push_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_push_ready: got=%0b exp=0", push_ready); end
    step();
    checks++; if (stream_out !== 1'b0) begin errors++; $display("[TB] FAIL basic_stream_pulse: got=%0b exp=0", stream_out); end
    for (int i = 0; i < 3; i++) begin
      rd_en  = 1'b1;
      pop_en = 1'b1;
      step();
      checks++; if (pop_data !== expv[i]) begin errors++; $display("[TB] FAIL basic_pop_data: got=%h exp=%h", pop_data, expv[i]); end
      checks++; if (pop_done !== 1'b1) begin errors++; $display("[TB] FAIL basic_pop_done: got=%0b exp=1", pop_done); end
    end
    idle_inputs();
    step();
    checks++; if (last_op !== 1'b0) begin errors++; $display("[TB] FAIL basic_last_op_early: got=%0b exp=0", last_op); end
    step();
    checks++; if (last_op !== 1'b1) begin errors++; $display("[TB] FAIL basic_last_op: got=%0b exp=1", last_op); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_idle_ready: got=%0b exp=1", push_ready); end
    step();
    checks++; if (last_op !== 1'b0) begin errors++; $display("[TB] FAIL basic_last_op_pulse: got=%0b exp=0", last_op); end
    exp_data = 16'h0011;
  endtask

  task automatic test_same_cycle();
    push_valid = 1'b1;
    push_data  = 16'h000A;
    step();
    push_data  = 16'h000B;
    fill_end   = 1'b1;
    step();
    idle_inputs();
    checks++; if (stream_out !== 1'b1) begin errors++; $display("[TB] FAIL same_stream_out: got=%0b exp=1", stream_out); end
    checks++; if (level !== LW'(2)) begin errors++; $display("[TB] FAIL same_level_fill: got=%0d exp=2", level); end
    rd_en  = 1'b1;
    pop_en = 1'b1;
    step();
    checks++; if (pop_data !== 16'h000B) begin errors++; $display("[TB] FAIL same_pop_data: got=%h exp=000b", pop_data); end
    checks++; if (level !== LW'(1)) begin errors++; $display("[TB] FAIL same_level_pop: got=%0d exp=1", level); end
    pop_en = 1'b0;
    step();
    checks++; if (pop_data !== 16'h000A) begin errors++; $display("[TB] FAIL same_next_read: got=%h exp=000a", pop_data); end
    checks++; if (pop_done !== 1'b0) begin errors++; $display("[TB] FAIL same_no_pop_done: got=%0b exp=0", pop_done); end
    rd_en  = 1'b0;
    pop_en = 1'b1;
    step();
    checks++; if (level !== LW'(0)) begin errors++; $display("[TB] FAIL same_level_empty: got=%0d exp=0", level); end
    rd_en  = 1'b1;
    pop_en = 1'b0;
    step();
    checks++; if (pop_data !== 16'h000A) begin errors++; $display("[TB] FAIL same_empty_read_hold: got=%h exp=000a", pop_data); end
    idle_inputs();
    step();
    checks++; if (last_op !== 1'b1) begin errors++; $display("[TB] FAIL same_last_op: got=%0b exp=1", last_op); end
    exp_data = 16'h000A;
    stk.delete();
  endtask

  task automatic test_full();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      push_valid = 1'b1;
      push_data  = DATA_W'($urandom);
      checks++; if (push_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_before: got=%0b exp=1 at %0d", push_ready, i); end
      stk.push_back(push_data);
      step();
    end
    checks++; if (stream_out !== 1'b1) begin errors++; $display("[TB] FAIL full_auto_stream: got=%0b exp=1", stream_out); end
    checks++; if (level !== LW'(DEPTH)) begin errors++; $display("[TB] FAIL full_level: got=%0d exp=%0d", level, DEPTH); end
    for (int i = 0; i < 2; i++) begin
      push_data = DATA_W'($urandom);
      step();
      checks++; if (push_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready_held: got=%0b exp=0", push_ready); end
      checks++; if (level !== LW'(DEPTH)) begin errors++; $display("[TB] FAIL full_level_held: got=%0d exp=%0d", level, DEPTH); end
    end
    push_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_en  = 1'b1;
      pop_en = 1'b1;
      w = stk.pop_back();
      step();
      checks++; if (pop_data !== w) begin errors++; $display("[TB] FAIL full_drain_data: got=%h exp=%h", pop_data, w); end
      exp_data = w;
    end
    wait_last_op("full");
  endtask

  task automatic test_empty_fill_end();
    idle_inputs();
    fill_end = 1'b1;
    step();
    fill_end = 1'b0;
    checks++; if (stream_out !== 1'b1) begin errors++; $display("[TB] FAIL empty_stream_out: got=%0b exp=1", stream_out); end
    checks++; if (level !== LW'(0)) begin errors++; $display("[TB] FAIL empty_level: got=%0d exp=0", level); end
    step();
    checks++; if (last_op !== 1'b0) begin errors++; $display("[TB] FAIL empty_last_op_early: got=%0b exp=0", last_op); end
    step();
    checks++; if (last_op !== 1'b1) begin errors++; $display("[TB] FAIL empty_last_op: got=%0b exp=1", last_op); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("[TB] FAIL empty_idle_ready: got=%0b exp=1", push_ready); end
  endtask

  task automatic test_random(input int iters);
    int  n;
    int  pushed;
    bit  bubble;
    bit  coincide;
    bit  exp_pd;
    for (int it = 0; it < iters; it++) begin
      n        = $urandom_range(1, DEPTH - 1);
      coincide = 1'($urandom_range(0, 1));
      pushed   = 0;
      while (pushed < n) begin
        bubble     = ($urandom_range(0, 3) == 0);
        push_valid = !bubble;
        push_data  = DATA_W'($urandom);
        rd_en      = 1'($urandom_range(0, 1));
        fill_end   = !bubble && coincide && (pushed == n - 1);
        step();
        if (!bubble) begin
          stk.push_back(push_data);
          pushed++;
        end
        checks++; if (int'(level) != stk.size()) begin errors++; $display("[TB] FAIL rand_fill_level: got=%0d exp=%0d", level, stk.size()); end
        checks++; if (pop_data !== exp_data) begin errors++; $display("[TB] FAIL rand_fill_hold: got=%h exp=%h", pop_data, exp_data); end
      end
      idle_inputs();
      if (!coincide) begin
        fill_end = 1'b1;
        step();
        fill_end = 1'b0;
      end
      checks++; if (stream_out !== 1'b1) begin errors++; $display("[TB] FAIL rand_stream_out: got=%0b exp=1", stream_out); end
      for (int cyc = 0; cyc < 400 && stk.size() > 0; cyc++) begin
        rd_en  = 1'($urandom_range(0, 1));
        pop_en = (cyc > 200) ? 1'b1 : 1'($urandom_range(0, 1));
        if (rd_en) exp_data = stk[$];
        exp_pd = pop_en;
        if (pop_en) void'(stk.pop_back());
        step();
        checks++; if (pop_data !== exp_data) begin errors++; $display("[TB] FAIL rand_pop_data: got=%h exp=%h", pop_data, exp_data); end
        checks++; if (int'(level) != stk.size()) begin errors++; $display("[TB] FAIL rand_level: got=%0d exp=%0d", level, stk.size()); end
        checks++; if (pop_done !== exp_pd) begin errors++; $display("[TB] FAIL rand_pop_done: got=%0b exp=%0b", pop_done, exp_pd); end
      end
      wait_last_op("rand");
      checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL rand_underflow: got=%0b exp=0", underflow); end
    end
  endtask

  task automatic test_underflow();
    idle_inputs();
    pop_en = 1'b1;
    step();
    pop_en = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL under_set: got=%0b exp=1", underflow); end
    checks++; if (level !== LW'(0)) begin errors++; $display("[TB] FAIL under_level: got=%0d exp=0", level); end
    checks++; if (pop_done !== 1'b0) begin errors++; $display("[TB] FAIL under_pop_done: got=%0b exp=0", pop_done); end
    step();
    step();
    checks++; if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL under_sticky: got=%0b exp=1", underflow); end
  endtask

  task automatic test_reset_mid_drain();
    push_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_data = DATA_W'($urandom);
      fill_end  = (i == 4);
      step();
    end
    idle_inputs();
    checks++; if (level !== LW'(5)) begin errors++; $display("[TB] FAIL rstmid_level_before: got=%0d exp=5", level); end
    rst = 1'b1;
    step();
    checks++; if (level !== LW'(0)) begin errors++; $display("[TB] FAIL rstmid_level: got=%0d exp=0", level); end
    checks++; if ({stream_out, pop_done, last_op, underflow} !== 4'b0) begin errors++; $display("[TB] FAIL rstmid_flags: got=%b exp=0000", {stream_out, pop_done, last_op, underflow}); end
    checks++; if (pop_data !== '0) begin errors++; $display("[TB] FAIL rstmid_pop_data: got=%h exp=0", pop_data); end
    checks++; if (push_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ready_in_reset: got=%0b exp=0", push_ready); end
    rst = 1'b0;
    #1;
    checks++; if (push_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready_after: got=%0b exp=1", push_ready); end
    stk.delete();
    exp_data = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_cycle();
    test_full();
    test_empty_fill_end();
    test_random(4);
    test_underflow();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
